// File: rtl/div8bc2_escalar_seq_pkg.sv
// Shared definitions for the iterative signed divider: FSM encodings and
// width-dependent saturation bounds (also used by the companion multiplier).
package div8bc2_escalar_seq_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Bounds of a w-bit two's-complement value, valid for 2 <= w <= 31.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/div8bc2_escalar_seq_if.sv
// Operand/result bundle of the divider. A request is start=1 while busy=0;
// it is consumed on that clock edge. Results are valid from the done pulse and held until the next one.
interface div8bc2_escalar_seq_if
  import div8bc2_escalar_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             overflow;
  logic             div_by_zero;
  state_t           dbg_state;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, overflow, div_by_zero, dbg_state
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, overflow, div_by_zero, dbg_state
  );

endinterface

// File: rtl/div8bc2_escalar_seq_div_restoring_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// Assumes i_rem < i_divisor (or i_divisor == 0, whose result is discarded later).
module div_restoring_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_partial;

  assign w_partial = {i_rem, i_dvd_bit};
  assign o_q_bit   = (w_partial >= {1'b0, i_divisor});
  // The true difference is below the divisor, so modular low-bit arithmetic is exact.
  assign o_rem     = o_q_bit ? (w_partial[WIDTH-1:0] - i_divisor) : w_partial[WIDTH-1:0];

endmodule

// File: rtl/div8bc2_escalar_seq.sv
// Iterative signed divider: one quotient bit per clock on magnitudes, then a
// fix-up cycle applies signs, saturation and the divide-by-zero override.
module div8bc2_escalar_seq
  import div8bc2_escalar_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  div8bc2_escalar_seq_if.slave bus
);

  localparam int               CW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
  localparam logic [CW-1:0]    CNT_TOP = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;      // |a| shifting out, quotient magnitude shifting in
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_a;
  logic             r_sign_q;
  logic             r_b_zero;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_ovf;
  logic             r_dbz;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_q;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;
  logic             w_fix_ovf;
  logic             w_fix_dbz;

  // |-2^(W-1)| wraps to the same bit pattern, which is correct as unsigned.
  assign w_abs_a = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign w_abs_b = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd_bit (r_dvd[WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_q_bit   (w_step_q)
  );

  always_comb begin
    w_fix_q   = r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
    w_fix_r   = r_a[WIDTH-1] ? (~r_rem + 1'b1) : r_rem;
    w_fix_ovf = 1'b0;
    w_fix_dbz = 1'b0;
    if (r_b_zero) begin
      w_fix_q   = r_a[WIDTH-1] ? SAT_MIN : SAT_MAX;
      w_fix_r   = r_a;
      w_fix_dbz = 1'b1;
    end else if (!r_sign_q && r_dvd[WIDTH-1]) begin
      // Positive magnitude of 2^(W-1): only reachable as -2^(W-1) / -1.
      w_fix_q   = SAT_MAX;
      w_fix_r   = '0;
      w_fix_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_a       <= '0;
      r_sign_q  <= 1'b0;
      r_b_zero  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_remd    <= '0;
      r_ovf     <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_dvd     <= w_abs_a;
            r_divisor <= w_abs_b;
            r_rem     <= '0;
            r_a       <= bus.a;
            r_sign_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_b_zero  <= (bus.b == '0);
            r_cnt     <= CNT_TOP;
            r_busy    <= 1'b1;
            r_state   <= ST_DIV;
          end
        end
        ST_DIV: begin
          r_rem <= w_step_rem;
          r_dvd <= {r_dvd[WIDTH-2:0], w_step_q};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_quot  <= w_fix_q;
          r_remd  <= w_fix_r;
          r_ovf   <= w_fix_ovf;
          r_dbz   <= w_fix_dbz;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remd;
  assign bus.overflow    = r_ovf;
  assign bus.div_by_zero = r_dbz;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_div8bc2_escalar_seq.sv
// Directed bench for div8bc2_escalar_seq: hand-computed vectors go into a
// scoreboard queue; a negedge monitor pops and compares on every done pulse.
module tb_div8bc2_escalar_seq;
  import div8bc2_escalar_seq_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
    logic         dbz;
    logic [31:0]  edge_no;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned edge_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  div8bc2_escalar_seq_if #(.WIDTH(W)) bus ();

  div8bc2_escalar_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no result (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient",    32'(bus.quotient),    32'(mon_e.q));
        check("remainder",   32'(bus.remainder),   32'(mon_e.r));
        check("overflow",    32'(bus.overflow),    32'(mon_e.ovf));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(mon_e.dbz));
        check("done_edge",   edge_cnt,             mon_e.edge_no);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; leaves the caller at the negedge after acceptance.
  task automatic issue(input int a, input int b, input int q, input int r,
                       input bit ovf, input bit dbz, input bit push);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = W'(a);
    bus.b     = W'(b);
    if (push) begin
      e.q       = W'(q);
      e.r       = W'(r);
      e.ovf     = ovf;
      e.dbz     = dbz;
      e.edge_no = edge_cnt + 10;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom_range(0, 255));
    bus.b     = W'($urandom_range(0, 255));
    check("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 30 cycles, expected done (t=%0t)", $time);
    end else begin
      check("busy_at_done", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic run(input int a, input int b, input int q, input int r,
                     input bit ovf, input bit dbz);
    issue(a, b, q, r, ovf, dbz, 1'b1);
    wait_done();
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_quotient"},    32'(bus.quotient),    32'd0);
    check({tag, "_remainder"},   32'(bus.remainder),   32'd0);
    check({tag, "_busy"},        32'(bus.busy),        32'd0);
    check({tag, "_done"},        32'(bus.done),        32'd0);
    check({tag, "_overflow"},    32'(bus.overflow),    32'd0);
    check({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
    check({tag, "_state"},       32'(bus.dbg_state),   32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #2;
    check_cleared("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // signs, truncation toward zero, remainder follows dividend
    run( 100,  7,   14,  2, 1'b0, 1'b0);
    run(-100,  7,  -14, -2, 1'b0, 1'b0);
    run( 100, -7,  -14,  2, 1'b0, 1'b0);
    run(  -1,  2,    0, -1, 1'b0, 1'b0);
    // saturation boundary
    run(-128, -1,  127,  0, 1'b1, 1'b0);
    run(-128,  1, -128,  0, 1'b0, 1'b0);
    // divide by zero
    run(   5,  0,  127,  5, 1'b0, 1'b1);
    run(  -5,  0, -128, -5, 1'b0, 1'b1);
    // flags are rewritten on the next result
    run(  77, -5,  -15,  2, 1'b0, 1'b0);

    // start while busy with different operands is ignored
    issue(50, 3, 16, 2, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd9;
    bus.b     = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (15) @(negedge clk);

    // back-to-back starts issued in the done cycle
    issue( 127, -128,  0, 127, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(-128, -128,  1,   0, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(-128,  127, -1,  -1, 1'b0, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);

    // reset mid-divide: outputs clear at once, no done, then normal operation
    issue(100, 7, 14, 2, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run(-77, 5, -15, -2, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("pending_results", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
